// File: rtl/pcap_replay_tx_gate.sv
// Per-port egress pacing gate: forwards whole packets from the replay FIFO,
// inserts a programmable inter-packet gap and stops after a packet limit.
module pcap_replay_tx_gate #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int TUSER_IPG_LSB      = 32
) (
    input  logic                            axis_aclk,
    input  logic                            axis_rst,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,

    input  logic                            replay_en,
    input  logic                            use_tuser_ipg,
    input  logic [31:0]                     ipg_cycles,
    input  logic [31:0]                     pkt_limit,
    output logic [31:0]                     pkt_count,
    output logic [63:0]                     byte_count,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      fsm_state
);

    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        replay_en_d;
    logic        rise;
    logic        hs, hs_last;
    logic        first_beat;
    logic        done_nxt;
    logic        limit_hit;
    logic [31:0] gap_cnt, gap_cnt_nxt;
    logic [31:0] gap_lat;
    logic [31:0] gap_val;
    logic [31:0] tuser_ipg;
    logic [31:0] pkt_base, pkt_inc;
    logic [63:0] byte_base, beat_bytes;

    // Valid/ready: a beat moves when s_axis_tvalid & s_axis_tready; the gate is
    // a pure wire in SEND and holds both sides idle in every other state.
    assign s_axis_tready = m_axis_tready & (state == SEND);
    assign m_axis_tvalid = s_axis_tvalid & (state == SEND);
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;

    assign hs        = s_axis_tvalid & s_axis_tready;
    assign hs_last   = hs & s_axis_tlast;
    assign rise      = replay_en & ~replay_en_d;
    assign tuser_ipg = s_axis_tuser[TUSER_IPG_LSB +: 32];

    assign busy      = (state == SEND) | (state == GAP);
    assign fsm_state = state;

    // A rising enable restarts statistics in the same cycle a beat may count.
    assign pkt_base  = rise ? 32'd0 : pkt_count;
    assign pkt_inc   = pkt_base + 32'd1;
    assign byte_base = rise ? 64'd0 : byte_count;
    assign limit_hit = (pkt_limit != 32'd0) && (pkt_inc == pkt_limit);

    always_comb begin
        beat_bytes = 64'd0;
        for (int i = 0; i < KEEP_W; i++) begin
            beat_bytes = beat_bytes + {63'd0, s_axis_tkeep[i]};
        end
    end

    // Single-beat packets carry their IPG on the beat being closed.
    always_comb begin
        gap_val = ipg_cycles;
        if (use_tuser_ipg) begin
            gap_val = first_beat ? tuser_ipg : gap_lat;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        done_nxt    = rise ? 1'b0 : done;
        case (state)
            IDLE: begin
                if (replay_en) state_nxt = SEND;
            end
            SEND: begin
                if (hs_last) begin
                    if (limit_hit) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (!replay_en) begin
                        state_nxt = IDLE;
                    end else if (gap_val == 32'd0) begin
                        state_nxt = SEND;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = gap_val - 32'd1;
                    end
                end
            end
            GAP: begin
                if (!replay_en) begin
                    state_nxt = IDLE;
                end else if (gap_cnt == 32'd0) begin
                    state_nxt = SEND;
                end else begin
                    gap_cnt_nxt = gap_cnt - 32'd1;
                end
            end
            DONE: begin
                if (!replay_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            state       <= IDLE;
            replay_en_d <= 1'b0;
            pkt_count   <= 32'd0;
            byte_count  <= 64'd0;
            done        <= 1'b0;
            gap_cnt     <= 32'd0;
            gap_lat     <= 32'd0;
            first_beat  <= 1'b1;
        end else begin
            state       <= state_nxt;
            replay_en_d <= replay_en;
            gap_cnt     <= gap_cnt_nxt;
            done        <= done_nxt;
            pkt_count   <= hs_last ? pkt_inc : pkt_base;
            byte_count  <= byte_base + (hs ? beat_bytes : 64'd0);
            if (hs) begin
                first_beat <= s_axis_tlast;
                if (first_beat) gap_lat <= tuser_ipg;
            end
        end
    end

endmodule

// File: tb/tb_pcap_replay_tx_gate.sv
// Directed bench for pcap_replay_tx_gate: queued upstream source, passthrough
// scoreboard on the egress stream, and timing/statistics checks per scenario.
module tb_pcap_replay_tx_gate;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;
    localparam logic [KW-1:0] FULL_KEEP = {KW{1'b1}};

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          replay_en;
    logic          use_tuser_ipg;
    logic [31:0]   ipg_cycles;
    logic [31:0]   pkt_limit;
    logic [31:0]   pkt_count;
    logic [63:0]   byte_count;
    logic          busy;
    logic          done;
    logic [1:0]    fsm_state;

    beat_t       src_q[$];
    logic [96:0] exp_q[$];
    int          acc_q[$];
    int          cyc;
    int          checks;
    int          errors;

    pcap_replay_tx_gate #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .TUSER_IPG_LSB     (32)
    ) dut (
        .axis_aclk    (clk),
        .axis_rst     (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .replay_en    (replay_en),
        .use_tuser_ipg(use_tuser_ipg),
        .ipg_cycles   (ipg_cycles),
        .pkt_limit    (pkt_limit),
        .pkt_count    (pkt_count),
        .byte_count   (byte_count),
        .busy         (busy),
        .done         (done),
        .fsm_state    (fsm_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Upstream source: presents the head of src_q, pops after each handshake,
    // and flushes on reset like the real replay FIFO.
    initial begin
        logic hs;
        logic clr;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        forever begin
            @(negedge clk);
            hs  = s_tvalid && s_tready && !rst;
            clr = rst;
            @(posedge clk);
            #2;
            if (clr) src_q.delete();
            else if (hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                s_tvalid = 1'b1;
                s_tdata  = src_q[0].data;
                s_tkeep  = src_q[0].keep;
                s_tuser  = src_q[0].user;
                s_tlast  = src_q[0].last;
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
        end
    end

    // Monitor: every presented egress beat must match the scoreboard head,
    // which also proves the beat stays stable under backpressure.
    always @(negedge clk) begin
        if (!rst && m_tvalid) begin
            logic [96:0] got;
            got = {m_tlast, m_tkeep, m_tdata[31:0], m_tuser[63:32]};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %h with empty expected queue", got);
            end else begin
                if (got !== exp_q[0]) begin
                    errors++;
                    $display("FAIL beat_compare: got %h expected %h", got, exp_q[0]);
                end
                if (m_tready) begin
                    void'(exp_q.pop_front());
                    acc_q.push_back(cyc);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] tag, input logic [KW-1:0] keep,
                             input logic [31:0] ipg, input logic last);
        beat_t b;
        b.data = {8{tag}};
        b.keep = keep;
        b.user = '0;
        b.user[63:32]  = ipg;
        b.user[127:96] = tag;
        b.last = last;
        src_q.push_back(b);
        exp_q.push_back({last, keep, b.data[31:0], ipg});
    endtask

    // Non-first beats carry IPG field 3 so only a first-beat latch gives the right gap.
    task automatic push_pkt(input int n, input logic [31:0] tag, input logic [31:0] ipg,
                            input logic [KW-1:0] last_keep);
        for (int i = 0; i < n; i++) begin
            push_beat(tag + i, (i == n - 1) ? last_keep : FULL_KEEP,
                      (i == 0) ? ipg : 32'd3, i == n - 1);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < 400) begin
            tick(1);
            n++;
        end
        chk(name, (src_q.size() == 0 && exp_q.size() == 0), 1);
        tick(2);
    endtask

    function automatic int acc_at(input int i);
        return (i < acc_q.size()) ? acc_q[i] : -1000;
    endfunction

    initial begin
        int en_cyc;
        int n;
        int acc_before;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        m_tready      = 1'b1;
        replay_en     = 1'b0;
        use_tuser_ipg = 1'b0;
        ipg_cycles    = 32'd0;
        pkt_limit     = 32'd0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_pkt_count", pkt_count, 0);
        chk("reset_byte_count", byte_count, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_tready", s_tready, 0);

        // 1: three back-to-back 2-beat packets, limit 3
        pkt_limit = 32'd3;
        push_pkt(2, 32'h1000, 32'd0, FULL_KEEP);
        push_pkt(2, 32'h2000, 32'd0, FULL_KEEP);
        push_pkt(2, 32'h3000, 32'd0, FULL_KEEP);
        acc_q.delete();
        replay_en = 1'b1;
        en_cyc = cyc;
        wait_drain("t1_drain");
        chk("t1_first_accept_latency", acc_at(0) - en_cyc, 1);
        chk("t1_back_to_back", acc_at(5) - acc_at(0), 5);
        chk("t1_pkt_count", pkt_count, 3);
        chk("t1_byte_count", byte_count, 192);
        chk("t1_done", done, 1);
        chk("t1_tready_held_low", s_tready, 0);
        chk("t1_state_done", fsm_state, 3);

        // 2: fixed IPG of 5 between two 1-beat packets
        replay_en = 1'b0;
        tick(2);
        chk("t2_idle_after_disable", fsm_state, 0);
        chk("t2_done_readback", done, 1);
        pkt_limit  = 32'd0;
        ipg_cycles = 32'd5;
        push_pkt(1, 32'h4000, 32'd0, FULL_KEEP);
        push_pkt(1, 32'h5000, 32'd0, FULL_KEEP);
        acc_q.delete();
        replay_en = 1'b1;
        wait_drain("t2_drain");
        chk("t2_gap_spacing", acc_at(1) - acc_at(0), 6);
        chk("t2_done_cleared", done, 0);
        chk("t2_pkt_count", pkt_count, 2);
        chk("t2_byte_count", byte_count, 64);

        // 3: per-packet IPG from tuser (A=10, B=0, C follows)
        use_tuser_ipg = 1'b1;
        ipg_cycles    = 32'd7;
        acc_q.delete();
        push_pkt(2, 32'h6000, 32'd10, FULL_KEEP);
        push_pkt(1, 32'h7000, 32'd0, FULL_KEEP);
        push_pkt(1, 32'h8000, 32'd0, FULL_KEEP);
        wait_drain("t3_drain");
        chk("t3_tuser_gap_a_to_b", acc_at(2) - acc_at(1), 11);
        chk("t3_zero_gap_b_to_c", acc_at(3) - acc_at(2), 1);
        chk("t3_pkt_count", pkt_count, 5);
        chk("t3_byte_count", byte_count, 192);

        // 4: disable mid-packet under 1010 backpressure
        use_tuser_ipg = 1'b0;
        ipg_cycles    = 32'd0;
        m_tready      = 1'b0;
        push_pkt(4, 32'h9000, 32'd0, FULL_KEEP);
        tick(1);
        for (int i = 0; i < 8; i++) begin
            m_tready = (i % 2 == 0);
            if (i == 2) replay_en = 1'b0;
            tick(1);
        end
        m_tready = 1'b1;
        tick(2);
        chk("t4_all_beats_forwarded", exp_q.size(), 0);
        chk("t4_state_idle", fsm_state, 0);
        chk("t4_no_tready", s_tready, 0);
        chk("t4_busy_low", busy, 0);
        chk("t4_pkt_count", pkt_count, 6);

        // 5: partial tkeep on the last beat, unlimited count, counters clear on rise
        replay_en = 1'b1;
        push_pkt(2, 32'hA000, 32'd0, {{(KW-4){1'b0}}, 4'hF});
        wait_drain("t5_drain");
        chk("t5_byte_count_partial", byte_count, 36);
        chk("t5_pkt_count", pkt_count, 1);
        chk("t5_done_never", done, 0);
        replay_en = 1'b0;
        tick(1);
        replay_en = 1'b1;
        tick(1);
        chk("t5_rise_clears_pkt", pkt_count, 0);
        chk("t5_rise_clears_bytes", byte_count, 0);

        // 6: reset while in GAP with counter 100
        ipg_cycles = 32'd101;
        acc_before = acc_q.size();
        push_pkt(1, 32'hB000, 32'd0, FULL_KEEP);
        n = 0;
        while (acc_q.size() == acc_before && n < 100) begin
            tick(1);
            n++;
        end
        chk("t6_beat_accepted", acc_q.size(), acc_before + 1);
        chk("t6_state_gap", fsm_state, 2);
        chk("t6_busy_in_gap", busy, 1);
        rst       = 1'b1;
        replay_en = 1'b0;
        tick(1);
        chk("t6_rst_state_idle", fsm_state, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_pkt_count", pkt_count, 0);
        chk("t6_rst_byte_count", byte_count, 0);
        chk("t6_rst_tvalid", m_tvalid, 0);
        chk("t6_rst_tready", s_tready, 0);
        rst = 1'b0;
        exp_q.delete();
        tick(2);
        ipg_cycles = 32'd0;
        acc_before = acc_q.size();
        push_pkt(1, 32'hC000, 32'd0, FULL_KEEP);
        tick(5);
        chk("t6_no_output_before_enable", acc_q.size(), acc_before);
        chk("t6_tready_before_enable", s_tready, 0);
        replay_en = 1'b1;
        wait_drain("t6_drain");
        chk("t6_pkt_after_enable", pkt_count, 1);
        chk("t6_bytes_after_enable", byte_count, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
